bitseq_sched: RTL and testbench

- Command-driven controller in front of NCH bitseq_player channels.
- Accepts 32-bit commands over a valid/ready port, typically driven by the host register/UART bridge.
- Holds each channel's len/rate_div/phase_off configuration.
- Serialises 32-bit pattern words into the single-bit player write ports and issues synchronized start/stop pulses to any subset of channels in the same clock.

---
 rtl/bitseq_sched.sv | 196 +++++++++++++++++++
 tb/tb_bitseq_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bitseq_sched.sv
// -----------------------------------------------------------------------------
// bitseq_sched
//   Command-driven front end for NCH bitseq_player channels. Accepts 32-bit
//   commands over a valid/ready port. It holds each channel's len / rate_div /
//   phase_off, and it serialises 32-bit pattern words LSB first into the
//   single-bit player write ports. It also issues start/stop pulses to any
//   subset of channels in the same clock.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   cmd_valid/ready command handshake (ready only while idle)
//   cmd_op/ch/data  opcode, target channel, operand
//   ch_playing      playing flags reported by the players
//   ch_start/stop   one-cycle start/stop pulses, one bit per channel
//   ch_len/rate/phase  packed per-channel configuration
//   ch_wr_en        per-channel write enable during a word write
//   wr_addr/wr_bit  shared write address / data
//   busy            word write in progress
//   err             sticky: [0] bad channel, [1] target playing, [2] write aborted
// -----------------------------------------------------------------------------
module bitseq_sched #(
  parameter int NCH = 4,
  parameter int AW  = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [2:0]             cmd_ch,
  input  logic [31:0]            cmd_data,
  input  logic [NCH-1:0]         ch_playing,
  output logic [NCH-1:0]         ch_start,
  output logic [NCH-1:0]         ch_stop,
  output logic [NCH*(AW+1)-1:0]  ch_len,
  output logic [NCH*32-1:0]      ch_rate,
  output logic [NCH*32-1:0]      ch_phase,
  output logic [NCH-1:0]         ch_wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic                   wr_bit,
  output logic                   busy,
  output logic [2:0]             err
);

  typedef enum logic [2:0] {
    OP_SET_ADDR   = 3'd0,
    OP_WRITE_WORD = 3'd1,
    OP_SET_LEN    = 3'd2,
    OP_SET_RATE   = 3'd3,
    OP_SET_PHASE  = 3'd4,
    OP_START      = 3'd5,
    OP_STOP       = 3'd6,
    OP_CLR_ERR    = 3'd7
  } op_t;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  // Largest legal length: the full memory depth, 2^AW.
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q;
  logic [31:0]     word_q;
  logic [4:0]      cnt_q;
  logic [NCH-1:0]  wsel_q;      // one-hot channel of the word being written
  logic [NCH-1:0]  start_q, stop_q;
  logic [2:0]      err_q, err_d;
  logic [AW:0]     len_q   [NCH];
  logic [31:0]     rate_q  [NCH];
  logic [31:0]     phase_q [NCH];

  op_t             op;
  logic            accept;
  logic [NCH-1:0]  ch_sel;
  logic            ch_ok, tgt_playing, cfg_op, cfg_ok;
  logic            abort, last_bit;
  logic            bad_ch_err, play_err;
  logic [AW:0]     len_sat;

  assign op     = op_t'(cmd_op);
  assign accept = cmd_valid && (state_q == S_IDLE);

  // Decode the channel into a one-hot select. An out-of-range index gives an
  // all-zero select, so it never needs a wide or out-of-bounds array index.
  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < NCH; i++) ch_sel[i] = (cmd_ch == 3'(i));
  end

  assign ch_ok       = |ch_sel;
  assign tgt_playing = |(ch_sel & ch_playing);
  assign cfg_op      = (op == OP_WRITE_WORD) || (op == OP_SET_LEN) ||
                       (op == OP_SET_RATE)   || (op == OP_SET_PHASE);
  assign cfg_ok      = ch_ok && !tgt_playing;
  assign len_sat     = (cmd_data > 32'(LEN_MAX)) ? LEN_MAX : cmd_data[AW:0];

  assign abort    = (state_q == S_WRITE) && |(wsel_q & ch_playing);
  assign last_bit = (cnt_q == 5'd31);

  assign bad_ch_err = accept && cfg_op && !ch_ok;
  assign play_err   = accept && ((cfg_op && ch_ok && tgt_playing) ||
                                 (op == OP_START && |(cmd_data[NCH-1:0] & ch_playing)));

  // NOTE: every signal written in a combinational block gets a default at the
  // top. Otherwise a path that leaves it unassigned infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept && op == OP_WRITE_WORD && cfg_ok) state_d = S_WRITE;
      S_WRITE: if (abort || last_bit)                       state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A clear and a new error in the same cycle: the new error survives.
  always_comb begin
    err_d = (accept && op == OP_CLR_ERR) ? 3'b000 : err_q;
    err_d = err_d | {abort, play_err, bad_ch_err};
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // The configuration registers are architecturally visible, so they are
  // reset. The player memories behind the write port are not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      wsel_q  <= '0;
      start_q <= '0;
      stop_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        len_q[i]   <= '0;
        rate_q[i]  <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      start_q <= '0;
      stop_q  <= '0;
      if (accept) begin
        unique case (op)
          OP_SET_ADDR: ptr_q <= cmd_data[AW-1:0];
          OP_WRITE_WORD: if (cfg_ok) begin
            word_q <= cmd_data;
            wsel_q <= ch_sel;
            cnt_q  <= '0;
          end
          OP_SET_LEN, OP_SET_RATE, OP_SET_PHASE: if (cfg_ok) begin
            for (int i = 0; i < NCH; i++) begin
              if (ch_sel[i]) begin
                if (op == OP_SET_LEN)   len_q[i]   <= len_sat;
                if (op == OP_SET_RATE)  rate_q[i]  <= cmd_data;
                if (op == OP_SET_PHASE) phase_q[i] <= cmd_data;
              end
            end
          end
          OP_START: start_q <= cmd_data[NCH-1:0] & ~ch_playing;
          OP_STOP:  stop_q  <= cmd_data[NCH-1:0];
          default: ;
        endcase
      end else if (state_q == S_WRITE && !abort) begin
        // An aborted write leaves the pointer where it was.
        if (last_bit) ptr_q <= ptr_q + AW'(32);
        else          cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign ch_len[g*(AW+1) +: AW+1] = len_q[g];
    assign ch_rate[g*32 +: 32]      = rate_q[g];
    assign ch_phase[g*32 +: 32]     = phase_q[g];
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_WRITE);
  assign err       = err_q;
  assign ch_start  = start_q;
  assign ch_stop   = stop_q;
  // The enable drops in the same cycle a target channel starts playing.
  assign ch_wr_en  = (busy && !abort) ? wsel_q : '0;
  assign wr_addr   = busy ? ptr_q + AW'(cnt_q) : '0;
  assign wr_bit    = busy && word_q[cnt_q];

endmodule

// File: tb/tb_bitseq_sched.sv
// -----------------------------------------------------------------------------
// tb_bitseq_sched
//   Directed bench for bitseq_sched (NCH=4, AW=14). A table of single-command
//   vectors covers configuration, saturation, channel and playing errors,
//   start/stop pulses and error clearing. Hand-written sequences cover the
//   32-cycle word write with address wrap, a mid-write abort, and a reset
//   applied mid-write.
// -----------------------------------------------------------------------------
module tb_bitseq_sched;
  localparam int NCH = 4;
  localparam int AW  = 14;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [2:0]            cmd_ch;
  logic [31:0]           cmd_data;
  logic [NCH-1:0]        ch_playing;
  logic [NCH-1:0]        ch_start, ch_stop, ch_wr_en;
  logic [NCH*(AW+1)-1:0] ch_len;
  logic [NCH*32-1:0]     ch_rate, ch_phase;
  logic [AW-1:0]         wr_addr;
  logic                  wr_bit, busy;
  logic [2:0]            err;

  int tests = 0;
  int fails = 0;

  bitseq_sched #(.NCH(NCH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data),
    .ch_playing(ch_playing), .ch_start(ch_start), .ch_stop(ch_stop),
    .ch_len(ch_len), .ch_rate(ch_rate), .ch_phase(ch_phase),
    .ch_wr_en(ch_wr_en), .wr_addr(wr_addr), .wr_bit(wr_bit),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one command at a negedge, hold it through the accepting posedge,
  // and return at the negedge of the following cycle. That is the cycle in
  // which the command's effects are visible.
  task automatic send(input logic [2:0] op, input logic [2:0] ch, input logic [31:0] data);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_data  = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  ch;
    logic [31:0] data;
    logic [3:0]  playing;
    int          chk;      // channel whose config is compared afterwards
    logic [14:0] len;
    logic [31:0] rate;
    logic [31:0] phase;
    logic [2:0]  err;
    logic [3:0]  start;
    logic [3:0]  stop;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] w;
    logic [13:0] a;

    // op ch data playing chk len rate phase err start stop
    vecs[0]  = '{3'd2, 3'd1, 32'd100,        4'b0000, 1, 15'd100,   32'd0, 32'd0, 3'b000, 4'b0000, 4'b0000};
    vecs[1]  = '{3'd3, 3'd1, 32'd3,          4'b0000, 1, 15'd100,   32'd3, 32'd0, 3'b000, 4'b0000, 4'b0000};
    vecs[2]  = '{3'd4, 3'd1, 32'd7,          4'b0000, 1, 15'd100,   32'd3, 32'd7, 3'b000, 4'b0000, 4'b0000};
    vecs[3]  = '{3'd7, 3'd0, 32'd0,          4'b0000, 0, 15'd0,     32'd0, 32'd0, 3'b000, 4'b0000, 4'b0000};
    vecs[4]  = '{3'd2, 3'd0, 32'hFFFF_FFFF,  4'b0000, 0, 15'd16384, 32'd0, 32'd0, 3'b000, 4'b0000, 4'b0000};
    vecs[5]  = '{3'd2, 3'd3, 32'd16385,      4'b0000, 3, 15'd16384, 32'd0, 32'd0, 3'b000, 4'b0000, 4'b0000};
    vecs[6]  = '{3'd2, 3'd2, 32'd16383,      4'b0000, 2, 15'd16383, 32'd0, 32'd0, 3'b000, 4'b0000, 4'b0000};
    vecs[7]  = '{3'd3, 3'd5, 32'd9,          4'b0000, 1, 15'd100,   32'd3, 32'd7, 3'b001, 4'b0000, 4'b0000};
    vecs[8]  = '{3'd7, 3'd0, 32'd0,          4'b0000, 1, 15'd100,   32'd3, 32'd7, 3'b000, 4'b0000, 4'b0000};
    vecs[9]  = '{3'd3, 3'd2, 32'd55,         4'b0100, 2, 15'd16383, 32'd0, 32'd0, 3'b010, 4'b0000, 4'b0000};
    vecs[10] = '{3'd7, 3'd0, 32'd0,          4'b0000, 2, 15'd16383, 32'd0, 32'd0, 3'b000, 4'b0000, 4'b0000};
    vecs[11] = '{3'd5, 3'd0, 32'b0101,       4'b0000, 2, 15'd16383, 32'd0, 32'd0, 3'b000, 4'b0101, 4'b0000};
    vecs[12] = '{3'd5, 3'd0, 32'b0011,       4'b0001, 2, 15'd16383, 32'd0, 32'd0, 3'b010, 4'b0010, 4'b0000};
    vecs[13] = '{3'd7, 3'd0, 32'd0,          4'b0000, 2, 15'd16383, 32'd0, 32'd0, 3'b000, 4'b0000, 4'b0000};
    vecs[14] = '{3'd6, 3'd0, 32'b1010,       4'b0000, 2, 15'd16383, 32'd0, 32'd0, 3'b000, 4'b0000, 4'b1010};
    vecs[15] = '{3'd0, 3'd7, 32'h0000_3FF0,  4'b0000, 1, 15'd100,   32'd3, 32'd7, 3'b000, 4'b0000, 4'b0000};

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_ch     = '0;
    cmd_data   = '0;
    ch_playing = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready",  32'(cmd_ready), 32'd1);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_err",    32'(err),       32'd0);
    check("rst_len",    32'(ch_len[59:30]), 32'd0);
    check("rst_rate",   ch_rate[31:0],  32'd0);
    check("rst_wr_en",  32'(ch_wr_en),  32'd0);
    check("rst_wr_addr",32'(wr_addr),   32'd0);
    check("rst_wr_bit", 32'(wr_bit),    32'd0);
    check("rst_start",  32'(ch_start | ch_stop), 32'd0);

    // Single-command vectors
    for (int i = 0; i < 16; i++) begin
      ch_playing = vecs[i].playing;
      send(vecs[i].op, vecs[i].ch, vecs[i].data);
      check($sformatf("vec%0d_len", i),   32'(ch_len[vecs[i].chk*15 +: 15]), 32'(vecs[i].len));
      check($sformatf("vec%0d_rate", i),  ch_rate[vecs[i].chk*32 +: 32],     vecs[i].rate);
      check($sformatf("vec%0d_phase", i), ch_phase[vecs[i].chk*32 +: 32],    vecs[i].phase);
      check($sformatf("vec%0d_err", i),   32'(err),      32'(vecs[i].err));
      check($sformatf("vec%0d_start", i), 32'(ch_start), 32'(vecs[i].start));
      check($sformatf("vec%0d_stop", i),  32'(ch_stop),  32'(vecs[i].stop));
      @(negedge clk);
      check($sformatf("vec%0d_pulse_end", i), 32'(ch_start | ch_stop), 32'd0);
    end
    ch_playing = '0;

    // Word write from 0x3FF0: the address wraps after 0x3FFF
    send(3'd0, 3'd0, 32'h0000_3FF0);
    w = 32'hA5A5_0001;
    send(3'd1, 3'd0, w);
    for (int k = 0; k < 32; k++) begin
      a = 14'h3FF0 + 14'(k);
      check($sformatf("wr0_en_%0d", k),    32'(ch_wr_en),  32'b0001);
      check($sformatf("wr0_addr_%0d", k),  32'(wr_addr),   32'(a));
      check($sformatf("wr0_bit_%0d", k),   32'(wr_bit),    32'(w[k]));
      check($sformatf("wr0_ready_%0d", k), 32'(cmd_ready), 32'd0);
      check($sformatf("wr0_busy_%0d", k),  32'(busy),      32'd1);
      @(negedge clk);
    end
    check("wr0_done_ready", 32'(cmd_ready), 32'd1);
    check("wr0_done_busy",  32'(busy),      32'd0);
    check("wr0_done_en",    32'(ch_wr_en),  32'd0);

    // Abort on ch2 at bit 10; the pointer should be 0x0010 after the wrap
    w = 32'h1234_5678;
    send(3'd1, 3'd2, w);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("wr2_en_%0d", k),   32'(ch_wr_en), 32'b0100);
      check($sformatf("wr2_addr_%0d", k), 32'(wr_addr),  32'h10 + 32'(k));
      check($sformatf("wr2_bit_%0d", k),  32'(wr_bit),   32'(w[k]));
      @(negedge clk);
    end
    ch_playing = 4'b0100;
    #1;
    check("abort_en_drop", 32'(ch_wr_en), 32'd0);
    @(negedge clk);
    check("abort_err",   32'(err),       32'b100);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_busy",  32'(busy),      32'd0);
    ch_playing = '0;
    send(3'd7, 3'd0, 32'd0);
    check("abort_clr", 32'(err), 32'd0);

    // The aborted write left the pointer at 0x0010
    send(3'd1, 3'd3, 32'hFFFF_FFFF);
    check("ptr_kept_addr", 32'(wr_addr),  32'h10);
    check("ptr_kept_en",   32'(ch_wr_en), 32'b1000);
    repeat (5) @(negedge clk);
    check("pre_rst_addr",  32'(wr_addr),  32'h15);

    // Reset asserted at bit 5
    rst_n = 1'b0;
    #1;
    check("midrst_en",    32'(ch_wr_en), 32'd0);
    check("midrst_busy",  32'(busy),     32'd0);
    check("midrst_len1",  32'(ch_len[29:15]), 32'd0);
    check("midrst_rate1", ch_rate[63:32],     32'd0);
    check("midrst_phase1",ch_phase[63:32],    32'd0);
    check("midrst_addr",  32'(wr_addr),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ready", 32'(cmd_ready), 32'd1);
    check("postrst_busy",  32'(busy),      32'd0);
    check("postrst_err",   32'(err),       32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
